// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexes four hex digits onto a common-anode 7-segment
// display, advancing one digit per rising edge of the slow scan clock.
module seg7_scan_driver #(
  parameter int DEAD_CYCLES = 8
) (
  input  logic        clk_1M,
  input  logic        reset,
  input  logic        clk_1k,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lead,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic        dbg_state,
  output logic [1:0]  dbg_idx
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam bit         NO_DEAD  = (DEAD_CYCLES == 0);
  localparam logic [7:0] LAST_CNT = NO_DEAD ? 8'd0 : 8'(DEAD_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_idx;
  logic [15:0] r_snap_dig;
  logic [3:0]  r_snap_dp;
  logic        r_s1, r_s2, r_s3;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;
  logic        r_frame;

  logic        w_tick;
  state_t      w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [1:0]  w_idx_nxt;
  logic [15:0] w_snap_dig_nxt;
  logic [3:0]  w_snap_dp_nxt;
  logic        w_frame_nxt;
  logic [3:0]  w_nib;
  logic        w_z1, w_z2, w_z3;
  logic        w_lead;
  logic        w_blanked;
  logic [3:0]  w_an_nxt;
  logic [6:0]  w_seg_nxt;
  logic        w_dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // clk_1k is unrelated to clk_1M: two flops resynchronise it, the third detects the rise.
  assign w_tick = r_s2 & ~r_s3;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_snap_dig_nxt = r_snap_dig;
    w_snap_dp_nxt  = r_snap_dp;
    w_frame_nxt    = 1'b0;
    if (w_tick) begin
      w_idx_nxt   = r_idx + 2'd1;
      w_cnt_nxt   = 8'd0;
      w_state_nxt = NO_DEAD ? ST_SHOW : ST_BLANK;
      if (r_idx == 2'd3) begin
        w_snap_dig_nxt = digits;
        w_snap_dp_nxt  = dp_in;
        w_frame_nxt    = 1'b1;
      end
    end else if (r_state == ST_BLANK) begin
      if (NO_DEAD || (r_cnt == LAST_CNT)) begin
        w_state_nxt = ST_SHOW;
        w_cnt_nxt   = 8'd0;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
    end
  end

  // Outputs are computed from next-state values so they change on the same edge as the state.
  always_comb begin
    w_nib = 4'h0;
    case (w_idx_nxt)
      2'd0: w_nib = w_snap_dig_nxt[3:0];
      2'd1: w_nib = w_snap_dig_nxt[7:4];
      2'd2: w_nib = w_snap_dig_nxt[11:8];
      2'd3: w_nib = w_snap_dig_nxt[15:12];
    endcase
    w_z3   = (w_snap_dig_nxt[15:12] == 4'h0);
    w_z2   = w_z3 && (w_snap_dig_nxt[11:8] == 4'h0);
    w_z1   = w_z2 && (w_snap_dig_nxt[7:4] == 4'h0);
    w_lead = 1'b0;
    case (w_idx_nxt)
      2'd1:    w_lead = w_z1;
      2'd2:    w_lead = w_z2;
      2'd3:    w_lead = w_z3;
      default: w_lead = 1'b0;
    endcase
    w_blanked = blank_lead && w_lead;
    w_an_nxt  = 4'hF;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if ((w_state_nxt == ST_SHOW) && !w_blanked) begin
      w_seg_nxt = decode(w_nib);
      w_dp_nxt  = ~w_snap_dp_nxt[w_idx_nxt];
      if (en) begin
        w_an_nxt = ~(4'b0001 << w_idx_nxt);
      end
    end
  end

  always_ff @(posedge clk_1M) begin
    if (reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_state    <= ST_BLANK;
      r_cnt      <= 8'd0;
      r_idx      <= 2'd0;
      r_snap_dig <= 16'h0000;
      r_snap_dp  <= 4'h0;
      r_an       <= 4'hF;
      r_seg      <= 7'h7F;
      r_dp       <= 1'b1;
      r_frame    <= 1'b0;
    end else begin
      r_s1       <= clk_1k;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_snap_dig <= w_snap_dig_nxt;
      r_snap_dp  <= w_snap_dp_nxt;
      r_an       <= w_an_nxt;
      r_seg      <= w_seg_nxt;
      r_dp       <= w_dp_nxt;
      r_frame    <= w_frame_nxt;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame;
  assign dbg_state  = r_state;
  assign dbg_idx    = r_idx;

endmodule
